nv_nvdla_cdp_wdma_req: RTL and testbench

//  CDP write-DMA request engine; counterpart to the CDP read DMA. Takes result atoms from the CDP datapath
//  and writes them to external memory over the mcif write-request interface (cmd packet, then data beats).

---
 rtl/nv_nvdla_cdp_wdma_pkg.sv | 30 +++
 rtl/nv_nvdla_cdp_wdma_req_if.sv | 22 ++
 rtl/nv_nvdla_cdp_wdma_addr_gen.sv | 99 +++++++++
 rtl/nv_nvdla_cdp_wdma_req.sv | 127 ++++++++++++
 tb/tb_nv_nvdla_cdp_wdma_req.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/nv_nvdla_cdp_wdma_pkg.sv
// rtl/nv_nvdla_cdp_wdma_pkg.sv - shared constants, payload layout and FSM states for the CDP write DMA
package nv_nvdla_cdp_wdma_pkg;

  localparam int   ATOM_BYTES    = 16;
  localparam logic PKT_CMD       = 1'b0;
  localparam logic PKT_DATA      = 1'b1;
  localparam int   PKT_TYPE_BIT  = 129;
  localparam int   DATA_MASK_BIT = 128;
  localparam int   CMD_ADDR_LSB  = 0;
  localparam int   CMD_SIZE_LSB  = 64;
  localparam int   CMD_SIZE_W    = 13;
  localparam int   CMD_ACK_BIT   = 77;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WAIT_ACK,
    ST_DONE
  } wdma_state_e;

  // Beats-minus-one of the next burst given atoms-left-minus-one in the line.
  function automatic logic [CMD_SIZE_W-1:0] burst_beats_m1(input logic [CMD_SIZE_W-1:0] remain_m1,
                                                           input int max_burst);
    logic [CMD_SIZE_W-1:0] cap;
    cap = CMD_SIZE_W'(max_burst - 1);
    return (remain_m1 > cap) ? cap : remain_m1;
  endfunction

endpackage

// File: rtl/nv_nvdla_cdp_wdma_req_if.sv
// rtl/nv_nvdla_cdp_wdma_req_if.sv - datapath beat input, mcif write request and write-ack signals
interface nv_nvdla_cdp_wdma_req_if #(
  parameter int DATA_W = 128
);
  logic              dp2wdma_valid;
  logic              dp2wdma_ready;
  logic [DATA_W-1:0] dp2wdma_pd;
  logic              cdp2mcif_wr_req_valid;
  logic              cdp2mcif_wr_req_ready;
  logic [129:0]      cdp2mcif_wr_req_pd;
  logic              mcif2cdp_wr_rsp_complete;

  modport master (
    input  dp2wdma_valid, dp2wdma_pd, cdp2mcif_wr_req_ready, mcif2cdp_wr_rsp_complete,
    output dp2wdma_ready, cdp2mcif_wr_req_valid, cdp2mcif_wr_req_pd
  );

  modport slave (
    output dp2wdma_valid, dp2wdma_pd, cdp2mcif_wr_req_ready, mcif2cdp_wr_rsp_complete,
    input  dp2wdma_ready, cdp2mcif_wr_req_valid, cdp2mcif_wr_req_pd
  );
endinterface

// File: rtl/nv_nvdla_cdp_wdma_addr_gen.sv
// rtl/nv_nvdla_cdp_wdma_addr_gen.sv - atom/line/surface walk, burst sizing and burst address
module nv_nvdla_cdp_wdma_addr_gen
  import nv_nvdla_cdp_wdma_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [63:0]           base_addr,
  input  logic [31:0]           line_stride,
  input  logic [31:0]           surf_stride,
  input  logic [12:0]           width,
  input  logic [12:0]           height,
  input  logic [9:0]            surf_num_m1,
  input  logic                  beat_accept,
  output logic [ADDR_W-1:0]     burst_addr,
  output logic [CMD_SIZE_W-1:0] burst_size,
  output logic                  last_beat,
  output logic                  last_cmd
);

  logic [12:0]       width_r, height_r, atom_cnt, line_cnt, atom_left;
  logic [9:0]        surf_max_r, surf_cnt;
  logic [12:0]       beat_cnt;
  logic [ADDR_W-1:0] line_stride_r, surf_stride_r, line_addr, surf_addr;
  logic [ADDR_W-1:0] next_line_addr, next_surf_addr, burst_bytes;
  logic              line_end, last_line, last_surf;

  // The burst size is capped at MAX_BURST-1, so it equals atoms-left only on the line's last burst.
  assign atom_left      = width_r - atom_cnt;
  assign line_end       = (atom_left == burst_size);
  assign last_line      = (line_cnt == height_r);
  assign last_surf      = (surf_cnt == surf_max_r);
  assign last_cmd       = line_end && last_line && last_surf;
  assign last_beat      = (beat_cnt == burst_size);
  assign next_line_addr = line_addr + line_stride_r;
  assign next_surf_addr = surf_addr + surf_stride_r;
  assign burst_bytes    = ADDR_W'(burst_size + 13'd1) * ADDR_W'(ATOM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_r       <= '0;
      height_r      <= '0;
      surf_max_r    <= '0;
      line_stride_r <= '0;
      surf_stride_r <= '0;
      atom_cnt      <= '0;
      line_cnt      <= '0;
      surf_cnt      <= '0;
      beat_cnt      <= '0;
      line_addr     <= '0;
      surf_addr     <= '0;
      burst_addr    <= '0;
      burst_size    <= '0;
    end else if (start) begin
      width_r       <= width;
      height_r      <= height;
      surf_max_r    <= surf_num_m1;
      line_stride_r <= ADDR_W'(line_stride);
      surf_stride_r <= ADDR_W'(surf_stride);
      atom_cnt      <= '0;
      line_cnt      <= '0;
      surf_cnt      <= '0;
      beat_cnt      <= '0;
      line_addr     <= ADDR_W'(base_addr);
      surf_addr     <= ADDR_W'(base_addr);
      burst_addr    <= ADDR_W'(base_addr);
      burst_size    <= burst_beats_m1(width, MAX_BURST);
    end else if (beat_accept) begin
      if (!last_beat) begin
        beat_cnt <= beat_cnt + 13'd1;
      end else begin
        beat_cnt <= '0;
        if (!line_end) begin
          atom_cnt   <= atom_cnt + burst_size + 13'd1;
          burst_addr <= burst_addr + burst_bytes;
          burst_size <= burst_beats_m1(atom_left - burst_size - 13'd1, MAX_BURST);
        end else if (!last_line) begin
          atom_cnt   <= '0;
          line_cnt   <= line_cnt + 13'd1;
          line_addr  <= next_line_addr;
          burst_addr <= next_line_addr;
          burst_size <= burst_beats_m1(width_r, MAX_BURST);
        end else if (!last_surf) begin
          atom_cnt   <= '0;
          line_cnt   <= '0;
          surf_cnt   <= surf_cnt + 10'd1;
          surf_addr  <= next_surf_addr;
          line_addr  <= next_surf_addr;
          burst_addr <= next_surf_addr;
          burst_size <= burst_beats_m1(width_r, MAX_BURST);
        end
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cdp_wdma_req.sv
// rtl/nv_nvdla_cdp_wdma_req.sv - CDP write-DMA request FSM: cmd/data packets to mcif, ack wait, done pulse
// Optional stall counter on dp2reg_perf_write_stall when CDP_WDMA_PERF_CNT_EN is defined.
module nv_nvdla_cdp_wdma_req
  import nv_nvdla_cdp_wdma_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 64
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  reg2dp_op_en,
  input  logic [31:0]           reg2dp_dst_base_addr_high,
  input  logic [31:0]           reg2dp_dst_base_addr_low,
  input  logic [31:0]           reg2dp_dst_line_stride,
  input  logic [31:0]           reg2dp_dst_surface_stride,
  input  logic [12:0]           reg2dp_width,
  input  logic [12:0]           reg2dp_height,
  input  logic [12:0]           reg2dp_channel,
  nv_nvdla_cdp_wdma_req_if.master wdma,
  output logic                  dp2reg_done,
  output logic [31:0]           dp2reg_perf_write_stall
);

  wdma_state_e           state;
  logic                  op_en_d, ack_seen, last_cmd_sent;
  logic                  layer_start, cmd_accept, beat_accept, last_beat, last_cmd;
  logic [ADDR_W-1:0]     burst_addr;
  logic [CMD_SIZE_W-1:0] burst_size;
  logic                  unused_channel_lsb;

  assign unused_channel_lsb = ^reg2dp_channel[2:0];
  assign layer_start = (state == ST_IDLE) && reg2dp_op_en && !op_en_d;
  assign cmd_accept  = (state == ST_CMD) && wdma.cdp2mcif_wr_req_ready;
  assign beat_accept = (state == ST_DATA) && wdma.dp2wdma_valid && wdma.cdp2mcif_wr_req_ready;

  nv_nvdla_cdp_wdma_addr_gen #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (nvdla_core_clk),
    .rst         (nvdla_core_rst),
    .start       (layer_start),
    .base_addr   ({reg2dp_dst_base_addr_high, reg2dp_dst_base_addr_low}),
    .line_stride (reg2dp_dst_line_stride),
    .surf_stride (reg2dp_dst_surface_stride),
    .width       (reg2dp_width),
    .height      (reg2dp_height),
    .surf_num_m1 (reg2dp_channel[12:3]),
    .beat_accept (beat_accept),
    .burst_addr  (burst_addr),
    .burst_size  (burst_size),
    .last_beat   (last_beat),
    .last_cmd    (last_cmd)
  );

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state         <= ST_IDLE;
      op_en_d       <= 1'b0;
      ack_seen      <= 1'b0;
      last_cmd_sent <= 1'b0;
      dp2reg_done   <= 1'b0;
    end else begin
      op_en_d     <= reg2dp_op_en;
      dp2reg_done <= 1'b0;
      // An ack may land while the final burst's data is still streaming; remember it.
      if (last_cmd_sent && wdma.mcif2cdp_wr_rsp_complete) ack_seen <= 1'b1;
      case (state)
        ST_IDLE: if (layer_start) begin
          state         <= ST_CMD;
          ack_seen      <= 1'b0;
          last_cmd_sent <= 1'b0;
        end
        ST_CMD: if (cmd_accept) begin
          state <= ST_DATA;
          if (last_cmd) last_cmd_sent <= 1'b1;
        end
        ST_DATA: if (beat_accept && last_beat) state <= last_cmd ? ST_WAIT_ACK : ST_CMD;
        ST_WAIT_ACK: if (ack_seen || wdma.mcif2cdp_wr_rsp_complete) begin
          state       <= ST_DONE;
          dp2reg_done <= 1'b1;
        end
        ST_DONE: begin
          state         <= ST_IDLE;
          ack_seen      <= 1'b0;
          last_cmd_sent <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wdma.cdp2mcif_wr_req_valid = 1'b0;
    wdma.dp2wdma_ready         = 1'b0;
    wdma.cdp2mcif_wr_req_pd    = {PKT_DATA, 1'b1, wdma.dp2wdma_pd};
    case (state)
      ST_CMD: begin
        wdma.cdp2mcif_wr_req_valid = 1'b1;
        wdma.cdp2mcif_wr_req_pd    = {PKT_CMD, 51'd0, last_cmd, burst_size, 64'(burst_addr)};
      end
      ST_DATA: begin
        wdma.cdp2mcif_wr_req_valid = wdma.dp2wdma_valid;
        wdma.dp2wdma_ready         = wdma.cdp2mcif_wr_req_ready;
      end
      default: ;
    endcase
  end

`ifdef CDP_WDMA_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      perf_stall_cnt <= '0;
    end else if (layer_start) begin
      perf_stall_cnt <= '0;
    end else if ((state == ST_CMD || state == ST_DATA) && wdma.cdp2mcif_wr_req_valid &&
                 !wdma.cdp2mcif_wr_req_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end

  assign dp2reg_perf_write_stall = perf_stall_cnt;
`else
  assign dp2reg_perf_write_stall = 32'h0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdp_wdma_req.sv
// tb/tb_nv_nvdla_cdp_wdma_req.sv - directed layers against hand-computed cmd/data/done expectations
module tb_nv_nvdla_cdp_wdma_req;

  logic        clk, rst, op_en;
  logic [31:0] base_hi, base_lo, line_stride, surf_stride;
  logic [12:0] width, height, channel;
  logic        done;
  logic [31:0] perf;

  nv_nvdla_cdp_wdma_req_if #(.DATA_W(128)) wdma_if ();

  nv_nvdla_cdp_wdma_req #(.MAX_BURST(4), .DATA_W(128), .ADDR_W(64)) dut (
    .nvdla_core_clk            (clk),
    .nvdla_core_rst            (rst),
    .reg2dp_op_en              (op_en),
    .reg2dp_dst_base_addr_high (base_hi),
    .reg2dp_dst_base_addr_low  (base_lo),
    .reg2dp_dst_line_stride    (line_stride),
    .reg2dp_dst_surface_stride (surf_stride),
    .reg2dp_width              (width),
    .reg2dp_height             (height),
    .reg2dp_channel            (channel),
    .wdma                      (wdma_if),
    .dp2reg_done               (done),
    .dp2reg_perf_write_stall   (perf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] beat_val(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {32'hD47A_0000 ^ u, ~u, u * 32'd3, 32'h5A5A_0000 + u};
  endfunction

  function automatic logic [128:0] mk_cmd(input logic [63:0] addr, input logic [12:0] size, input logic ack);
    return {51'd0, ack, size, addr};
  endfunction

  // Environment knobs (written by the main sequence only)
  int  gen = 0;
  int  n_beats = 0;
  bit  stall_en = 0;
  int  ack_mode = 0;  // 0: ack 3 cycles after last data, 1: ack right after the require_ack cmd

  // Environment observations (written by the environment loop only)
  logic [128:0] cmd_q[$];
  logic [128:0] dat_q[$];
  logic [129:0] prev_pd;
  bit           prev_stall, prev_acc;
  int           env_gen = 0, dp_idx = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  int           last_acc_cyc = 0, ack_cyc = 0, ack_cd = 0, stall_cnt = 0;

  // Drive at negedge, then sample #1 later: the sampled values are what the next posedge acts on.
  initial begin
    wdma_if.dp2wdma_valid            = 1'b0;
    wdma_if.dp2wdma_pd               = '0;
    wdma_if.cdp2mcif_wr_req_ready    = 1'b0;
    wdma_if.mcif2cdp_wr_rsp_complete = 1'b0;
    prev_stall = 0;
    prev_acc   = 0;
    prev_pd    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (env_gen != gen) begin
        env_gen = gen;
        dp_idx = 0;
        cmd_q.delete();
        dat_q.delete();
        done_cnt = 0;
        stall_cnt = 0;
        ack_cd = 0;
        prev_stall = 0;
      end else if (prev_acc) begin
        dp_idx++;
      end
      wdma_if.dp2wdma_valid         = (dp_idx < n_beats);
      wdma_if.dp2wdma_pd            = beat_val(dp_idx);
      wdma_if.cdp2mcif_wr_req_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      wdma_if.mcif2cdp_wr_rsp_complete = 1'b0;
      if (ack_cd != 0) begin
        ack_cd--;
        if (ack_cd == 0) begin
          wdma_if.mcif2cdp_wr_rsp_complete = 1'b1;
          ack_cyc = cyc;
        end
      end
      #1;
      if (!rst) begin
        if (prev_stall) begin
          check("pd_stable", wdma_if.cdp2mcif_wr_req_pd, prev_pd);
          check("valid_held", 130'(wdma_if.cdp2mcif_wr_req_valid), 130'(1));
        end
        if (wdma_if.cdp2mcif_wr_req_valid && wdma_if.cdp2mcif_wr_req_ready) begin
          if (!wdma_if.cdp2mcif_wr_req_pd[129]) begin
            cmd_q.push_back(wdma_if.cdp2mcif_wr_req_pd[128:0]);
            if (wdma_if.cdp2mcif_wr_req_pd[77] && ack_mode == 1) ack_cd = 1;
          end else begin
            dat_q.push_back(wdma_if.cdp2mcif_wr_req_pd[128:0]);
            last_acc_cyc = cyc;
            if (dat_q.size() == n_beats && ack_mode == 0) ack_cd = 3;
          end
        end
        if (wdma_if.cdp2mcif_wr_req_valid && !wdma_if.cdp2mcif_wr_req_ready) stall_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = wdma_if.cdp2mcif_wr_req_valid && !wdma_if.cdp2mcif_wr_req_ready;
        prev_pd    = wdma_if.cdp2mcif_wr_req_pd;
      end else begin
        prev_stall = 0;
      end
      prev_acc = wdma_if.dp2wdma_valid && wdma_if.dp2wdma_ready;
    end
  end

  logic [128:0] exp_cmd[$];

  task automatic start_layer(input logic [12:0] w, input logic [12:0] h, input logic [12:0] c,
                             input logic [63:0] base, input logic [31:0] ls, input logic [31:0] ss,
                             input int nb, input bit stall, input int mode);
    width = w; height = h; channel = c;
    base_hi = base[63:32]; base_lo = base[31:0];
    line_stride = ls; surf_stride = ss;
    n_beats = nb; stall_en = stall; ack_mode = mode;
    gen++;
    repeat (2) @(negedge clk);
    op_en = 1'b1;
  endtask

  task automatic run_layer(input string name, input logic [12:0] w, input logic [12:0] h,
                           input logic [12:0] c, input logic [63:0] base, input logic [31:0] ls,
                           input logic [31:0] ss, input int nb, input bit stall, input int mode);
    logic [128:0] got;
    logic [31:0]  exp_perf;
    start_layer(w, h, c, base, ls, ss, nb, stall, mode);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    check({name, "_done_seen"}, 130'(done_cnt != 0), 130'(1));
    repeat (4) @(negedge clk);
    op_en = 1'b0;
    check({name, "_done_pulses"}, 130'(done_cnt), 130'(1));
    check({name, "_cmd_count"}, 130'(cmd_q.size()), 130'(exp_cmd.size()));
    foreach (exp_cmd[i]) begin
      got = (i < cmd_q.size()) ? cmd_q[i] : '1;
      check($sformatf("%s_cmd%0d", name, i), 130'(got), 130'(exp_cmd[i]));
    end
    check({name, "_beat_count"}, 130'(dat_q.size()), 130'(nb));
    for (int i = 0; i < nb; i++) begin
      got = (i < dat_q.size()) ? dat_q[i] : '0;
      check($sformatf("%s_beat%0d", name, i), 130'(got), 130'({1'b1, beat_val(i)}));
    end
    if (mode == 0) check({name, "_done_after_ack"}, 130'(done_cyc - ack_cyc), 130'(1));
    else           check({name, "_done_after_last_beat"}, 130'(done_cyc - last_acc_cyc), 130'(2));
`ifdef CDP_WDMA_PERF_CNT_EN
    exp_perf = 32'(stall_cnt);
`else
    exp_perf = 32'h0;
`endif
    check({name, "_perf_stall"}, 130'(perf), 130'(exp_perf));
    exp_cmd.delete();
  endtask

  initial begin
    rst = 1'b1; op_en = 1'b0;
    base_hi = '0; base_lo = '0; line_stride = '0; surf_stride = '0;
    width = '0; height = '0; channel = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_req_valid", 130'(wdma_if.cdp2mcif_wr_req_valid), 130'(0));
    check("rst_dp_ready", 130'(wdma_if.dp2wdma_ready), 130'(0));
    check("rst_done", 130'(done), 130'(0));
    check("rst_perf", 130'(perf), 130'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    exp_cmd.push_back(mk_cmd(64'h1000, 13'd0, 1'b1));
    run_layer("single", 13'd0, 13'd0, 13'd0, 64'h1000, 32'h20, 32'h40, 1, 0, 0);

    exp_cmd.push_back(mk_cmd(64'h1_0000_2000, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h1_0000_2040, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h1_0000_2080, 13'd1, 1'b1));
    run_layer("split", 13'd9, 13'd0, 13'd0, 64'h1_0000_2000, 32'h0, 32'h0, 10, 0, 0);

    exp_cmd.push_back(mk_cmd(64'h8000, 13'd0, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h8100, 13'd0, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h9000, 13'd0, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h9100, 13'd0, 1'b1));
    run_layer("surf", 13'd0, 13'd1, 13'd15, 64'h8000, 32'h100, 32'h1000, 4, 0, 0);

    exp_cmd.push_back(mk_cmd(64'h5000, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h5040, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h5080, 13'd1, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h5200, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h5240, 13'd3, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h5280, 13'd1, 1'b1));
    run_layer("stall", 13'd9, 13'd1, 13'd0, 64'h5000, 32'h200, 32'h0, 20, 1, 0);

    exp_cmd.push_back(mk_cmd(64'h3000, 13'd3, 1'b1));
    run_layer("early_ack", 13'd3, 13'd0, 13'd0, 64'h3000, 32'h0, 32'h0, 4, 0, 1);

    // Abort a layer partway through its first burst.
    start_layer(13'd9, 13'd0, 13'd0, 64'h4000, 32'h0, 32'h0, 10, 0, 0);
    for (int i = 0; i < 200 && dat_q.size() < 2; i++) @(negedge clk);
    check("abort_reached_data", 130'(dat_q.size() >= 2), 130'(1));
    rst = 1'b1;
    op_en = 1'b0;
    @(negedge clk);
    check("abort_valid_low", 130'(wdma_if.cdp2mcif_wr_req_valid), 130'(0));
    check("abort_ready_low", 130'(wdma_if.dp2wdma_ready), 130'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 130'(done_cnt), 130'(0));

    exp_cmd.push_back(mk_cmd(64'hFFFF_FFFF_FFFF_FF00, 13'd0, 1'b0));
    exp_cmd.push_back(mk_cmd(64'h0, 13'd0, 1'b1));
    run_layer("wrap", 13'd0, 13'd1, 13'd0, 64'hFFFF_FFFF_FFFF_FF00, 32'h100, 32'h0, 2, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
